final_soc_nios2_qsys_0_oci_dct_packer: RTL and testbench

Packs the Nios II direct-control-transfer (DCT) trace stream into 30-bit frames. It accepts one 2-bit branch code per cycle from the CPU trace port and shifts it into a live buffer. When the buffer is full or a flush occurs, it hands the frame to the OCI trace FIFO through a one-entry valid/ready slot. It sits directly upstream of the OCI test bench and trace FIFO, and drives their `dct_buffer`/`dct_count` inputs.

---
 rtl/final_soc_nios2_qsys_0_oci_pkg.sv | 37 +++
 rtl/final_soc_nios2_qsys_0_oci_dct_slot.sv | 97 +++++++++
 rtl/final_soc_nios2_qsys_0_oci_dct_packer.sv | 119 +++++++++++
 tb/tb_final_soc_nios2_qsys_0_oci_dct_packer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/final_soc_nios2_qsys_0_oci_pkg.sv
// ---------------------------------------------------------------------------
// final_soc_nios2_qsys_0_oci_pkg
//
// Purpose:
//   Shared constants and types for the OCI direct-control-transfer (DCT)
//   trace packer. It holds the frame geometry, the branch-code encoding and
//   the state encoding of the one-entry frame slot.
//
// Contents:
//   DCT_ENTRIES  - codes per frame
//   DCT_CODE_W   - bits per branch code
//   DCT_BUF_W    - width of a full frame (DCT_ENTRIES * DCT_CODE_W)
//   DCT_CNT_W    - width of a code counter able to hold 0..DCT_ENTRIES
//   dct_code_t   - branch-code encoding from the CPU trace port
//   slot_state_t - occupancy of the frame hand-off slot
// ---------------------------------------------------------------------------
package final_soc_nios2_qsys_0_oci_pkg;

  localparam int DCT_ENTRIES = 15;
  localparam int DCT_CODE_W  = 2;
  localparam int DCT_BUF_W   = DCT_ENTRIES * DCT_CODE_W;
  localparam int DCT_CNT_W   = $clog2(DCT_ENTRIES + 1);

  // The reserved code is still stored verbatim; the packer never filters codes.
  typedef enum logic [DCT_CODE_W-1:0] {
    DCT_RESERVED  = 2'b00,
    DCT_NOT_TAKEN = 2'b01,
    DCT_TAKEN     = 2'b10,
    DCT_INDIRECT  = 2'b11
  } dct_code_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/final_soc_nios2_qsys_0_oci_dct_slot.sv
// ---------------------------------------------------------------------------
// final_soc_nios2_qsys_0_oci_dct_slot
//
// Purpose:
//   One-entry valid/ready register between the DCT packer and the OCI trace
//   FIFO, plus the sticky overflow flag. A new frame is accepted when the
//   slot is empty or is being drained on the same edge, which gives one frame
//   per cycle with no bubble. A frame arriving while the slot is full and not
//   drained is dropped and the old frame is kept.
//
// Ports:
//   clk          in   clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   emit         in   packer offers a frame this cycle
//   emit_data    in   frame payload offered by the packer
//   emit_count   in   number of codes in the offered frame
//   frame_ready  in   downstream takes the frame held in the slot
//   overflow_clr in   clears the sticky overflow flag
//   frame_valid  out  slot holds a frame
//   frame_data   out  frame payload
//   frame_count  out  codes in the held frame
//   overflow     out  sticky: at least one frame was dropped
// ---------------------------------------------------------------------------
module final_soc_nios2_qsys_0_oci_dct_slot
  import final_soc_nios2_qsys_0_oci_pkg::*;
#(
  parameter int BUF_W = DCT_BUF_W,
  parameter int CNT_W = DCT_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             emit,
  input  logic [BUF_W-1:0] emit_data,
  input  logic [CNT_W-1:0] emit_count,
  input  logic             frame_ready,
  input  logic             overflow_clr,
  output logic             frame_valid,
  output logic [BUF_W-1:0] frame_data,
  output logic [CNT_W-1:0] frame_count,
  output logic             overflow
);

  slot_state_t      state_q;
  logic [BUF_W-1:0] data_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             drop;

  // A frame is lost only when the slot is occupied and not being drained.
  assign drop = (state_q == SLOT_FULL) & emit & ~frame_ready;

  // Slot FSM together with its payload and the overflow flag. The payload is
  // only written when a frame is actually accepted, so it stays stable while
  // the slot waits for frame_ready. Setting the overflow flag wins over a
  // simultaneous clear so that no drop event can go unreported.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SLOT_EMPTY;
      data_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        SLOT_EMPTY: begin
          if (emit) begin
            state_q <= SLOT_FULL;
            data_q  <= emit_data;
            count_q <= emit_count;
          end
        end
        SLOT_FULL: begin
          if (emit) begin
            if (frame_ready) begin
              data_q  <= emit_data;
              count_q <= emit_count;
            end
          end else if (frame_ready) begin
            state_q <= SLOT_EMPTY;
          end
        end
        default: state_q <= SLOT_EMPTY;
      endcase

      if (drop) begin
        overflow_q <= 1'b1;
      end else if (overflow_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign frame_valid = (state_q == SLOT_FULL);
  assign frame_data  = data_q;
  assign frame_count = count_q;
  assign overflow    = overflow_q;

endmodule

// File: rtl/final_soc_nios2_qsys_0_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// final_soc_nios2_qsys_0_oci_dct_packer
//
// Purpose:
//   Packs the Nios II DCT trace stream (one 2-bit branch code per cycle) into
//   30-bit frames. Codes are shifted into a live buffer, newest code in the
//   low bits. A frame is emitted when the 15th code arrives, on flush, or
//   when tracing is switched off, and is handed to the trace FIFO through a
//   one-entry valid/ready slot.
//
// Ports:
//   clk          in   clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   trc_on       in   trace enable; codes are ignored while low
//   dct_valid    in   a code is presented this cycle
//   dct_code     in   branch code (01 not taken, 10 taken, 11 indirect)
//   flush        in   emit the partial frame, if any
//   dct_buffer   out  live buffer, newest code in [1:0]
//   dct_count    out  live code count, 0..14
//   frame_valid  out  frame slot occupied
//   frame_data   out  frame payload
//   frame_count  out  codes in frame, 1..15
//   frame_ready  in   downstream accepts the frame
//   overflow     out  sticky: a frame was dropped
//   overflow_clr in   clears overflow
// ---------------------------------------------------------------------------
module final_soc_nios2_qsys_0_oci_dct_packer #(
  parameter int DCT_ENTRIES = final_soc_nios2_qsys_0_oci_pkg::DCT_ENTRIES,
  parameter int DCT_CODE_W  = final_soc_nios2_qsys_0_oci_pkg::DCT_CODE_W
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              trc_on,
  input  logic                              dct_valid,
  input  logic [DCT_CODE_W-1:0]             dct_code,
  input  logic                              flush,
  output logic [DCT_ENTRIES*DCT_CODE_W-1:0] dct_buffer,
  output logic [$clog2(DCT_ENTRIES+1)-1:0]  dct_count,
  output logic                              frame_valid,
  output logic [DCT_ENTRIES*DCT_CODE_W-1:0] frame_data,
  output logic [$clog2(DCT_ENTRIES+1)-1:0]  frame_count,
  input  logic                              frame_ready,
  output logic                              overflow,
  input  logic                              overflow_clr
);

  import final_soc_nios2_qsys_0_oci_pkg::*;

  localparam int BUF_W = DCT_ENTRIES * DCT_CODE_W;
  localparam int CNT_W = $clog2(DCT_ENTRIES + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DCT_ENTRIES);

  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trc_on_q, trc_on_d;

  logic             accept;
  logic [BUF_W-1:0] buf_post;
  logic [CNT_W-1:0] cnt_post;
  logic             trc_fall;
  logic             emit;

  assign accept   = trc_on & dct_valid;
  assign trc_fall = trc_on_q & ~trc_on;

  // Emit decisions look at the buffer as it would be after this cycle's
  // code, so the code that completes a frame (or arrives alongside a flush)
  // travels with that frame instead of starting the next one. Because the
  // 15th code always emits, the live count never shows 15.
  always_comb begin
    buf_post = buf_q;
    cnt_post = cnt_q;
    if (accept) begin
      buf_post = {buf_q[BUF_W-DCT_CODE_W-1:0], dct_code};
      cnt_post = cnt_q + CNT_W'(1);
    end

    emit = (cnt_post == FULL_CNT) |
           ((cnt_post != '0) & (flush | trc_fall));

    buf_d    = emit ? '0 : buf_post;
    cnt_d    = emit ? '0 : cnt_post;
    trc_on_d = trc_on;
  end

  // Live buffer, count and the registered trc_on used for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q    <= '0;
      cnt_q    <= '0;
      trc_on_q <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      trc_on_q <= trc_on_d;
    end
  end

  assign dct_buffer = buf_q;
  assign dct_count  = cnt_q;

  final_soc_nios2_qsys_0_oci_dct_slot #(
    .BUF_W (BUF_W),
    .CNT_W (CNT_W)
  ) u_slot (
    .clk          (clk),
    .reset_n      (reset_n),
    .emit         (emit),
    .emit_data    (buf_post),
    .emit_count   (cnt_post),
    .frame_ready  (frame_ready),
    .overflow_clr (overflow_clr),
    .frame_valid  (frame_valid),
    .frame_data   (frame_data),
    .frame_count  (frame_count),
    .overflow     (overflow)
  );

endmodule

// File: tb/tb_final_soc_nios2_qsys_0_oci_dct_packer.sv
// ---------------------------------------------------------------------------
// tb_final_soc_nios2_qsys_0_oci_dct_packer
//
// Self-checking bench for the DCT packer: a table of hand-derived vectors,
// hand-written corner sequences and a randomized run, all compared against a
// queue-based reference model of the packer.
// ---------------------------------------------------------------------------
module tb_final_soc_nios2_qsys_0_oci_dct_packer;
  import final_soc_nios2_qsys_0_oci_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        trc_on;
  logic        dct_valid;
  logic [1:0]  dct_code;
  logic        flush;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        frame_valid;
  logic [29:0] frame_data;
  logic [3:0]  frame_count;
  logic        frame_ready;
  logic        overflow;
  logic        overflow_clr;

  int n_vectors     = 0;
  int n_miscompares = 0;

  always #5 clk = ~clk;

  final_soc_nios2_qsys_0_oci_dct_packer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .trc_on       (trc_on),
    .dct_valid    (dct_valid),
    .dct_code     (dct_code),
    .flush        (flush),
    .dct_buffer   (dct_buffer),
    .dct_count    (dct_count),
    .frame_valid  (frame_valid),
    .frame_data   (frame_data),
    .frame_count  (frame_count),
    .frame_ready  (frame_ready),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  // Reference model: the live frame is a queue of codes, the slot is a
  // valid bit plus payload.
  int     live_q[$];
  bit     m_prev_trc;
  bit     m_valid;
  longint m_data;
  int     m_count;
  bit     m_ovf;

  typedef struct {
    logic        trc;
    logic        valid;
    logic [1:0]  code;
    logic        fl;
    logic        rdy;
    logic        oclr;
    logic [29:0] exp_buf;
    logic [3:0]  exp_cnt;
    logic        exp_fv;
    logic [29:0] exp_fd;
    logic [3:0]  exp_fc;
    logic        exp_ovf;
  } vec_t;

  vec_t table_q[$];

  function automatic longint pack_codes(input int codes[$]);
    longint v = 0;
    foreach (codes[i]) v = v * 4 + codes[i];
    return v;
  endfunction

  function automatic void add_vec(input logic trc, input logic valid,
                                  input logic [1:0] code, input logic fl,
                                  input logic rdy, input logic oclr,
                                  input logic [29:0] eb, input logic [3:0] ec,
                                  input logic efv, input logic [29:0] efd,
                                  input logic [3:0] efc, input logic eovf);
    vec_t v;
    v.trc = trc; v.valid = valid; v.code = code; v.fl = fl;
    v.rdy = rdy; v.oclr = oclr;
    v.exp_buf = eb; v.exp_cnt = ec; v.exp_fv = efv;
    v.exp_fd = efd; v.exp_fc = efc; v.exp_ovf = eovf;
    table_q.push_back(v);
  endfunction

  task automatic check_val(input string name, input logic [31:0] actual,
                           input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    live_q.delete();
    m_prev_trc = 1'b0;
    m_valid    = 1'b0;
    m_data     = 0;
    m_count    = 0;
    m_ovf      = 1'b0;
  endtask

  task automatic model_step(input logic trc, input logic valid,
                            input logic [1:0] code, input logic fl,
                            input logic rdy, input logic oclr);
    bit emit;
    bit drop;
    int n;
    if (trc && valid) live_q.push_back(int'(code));
    n = live_q.size();
    emit = (n == DCT_ENTRIES) || (n > 0 && (fl || (m_prev_trc && !trc)));
    drop = 1'b0;
    if (emit) begin
      if (!m_valid || rdy) begin
        m_valid = 1'b1;
        m_data  = pack_codes(live_q);
        m_count = n;
      end else begin
        drop = 1'b1;
      end
      live_q.delete();
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (drop) m_ovf = 1'b1;
    else if (oclr) m_ovf = 1'b0;
    m_prev_trc = trc;
  endtask

  task automatic checkOutput(input string tag);
    check_val({tag, ".dct_buffer"}, 32'(dct_buffer), 32'(pack_codes(live_q)));
    check_val({tag, ".dct_count"}, 32'(dct_count), 32'(live_q.size()));
    check_val({tag, ".frame_valid"}, 32'(frame_valid), 32'(m_valid));
    if (m_valid) begin
      check_val({tag, ".frame_data"}, 32'(frame_data), 32'(m_data));
      check_val({tag, ".frame_count"}, 32'(frame_count), 32'(m_count));
    end
    check_val({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  // Drives one cycle of inputs, lets the edge happen, advances the model
  // and compares all outputs 1 time unit after the edge.
  task automatic applyStimulus(input string tag, input logic trc,
                               input logic valid, input logic [1:0] code,
                               input logic fl, input logic rdy,
                               input logic oclr);
    trc_on       = trc;
    dct_valid    = valid;
    dct_code     = code;
    flush        = fl;
    frame_ready  = rdy;
    overflow_clr = oclr;
    @(posedge clk);
    #1;
    model_step(trc, valid, code, fl, rdy, oclr);
    checkOutput(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, ".dct_buffer"}, 32'(dct_buffer), 32'h0);
    check_val({tag, ".dct_count"}, 32'(dct_count), 32'h0);
    check_val({tag, ".frame_valid"}, 32'(frame_valid), 32'h0);
    check_val({tag, ".frame_data"}, 32'(frame_data), 32'h0);
    check_val({tag, ".frame_count"}, 32'(frame_count), 32'h0);
    check_val({tag, ".overflow"}, 32'(overflow), 32'h0);
  endtask

  initial begin
    logic [29:0] r;
    logic [1:0]  c;
    logic [29:0] held_data;

    reset_n      = 1'b0;
    trc_on       = 1'b0;
    dct_valid    = 1'b0;
    dct_code     = 2'b00;
    flush        = 1'b0;
    frame_ready  = 1'b0;
    overflow_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Table: 15 alternating taken/not-taken codes, a 3-code flushed frame,
    // a redundant flush, then 15 taken codes.
    r = '0;
    for (int i = 0; i < 15; i++) begin
      c = (i % 2 == 0) ? 2'b10 : 2'b01;
      if (i < 14) begin
        r = (r << 2) | 30'(c);
        add_vec(1, 1, c, 0, 1, 0, r, 4'(i + 1), 0, 30'h0, 4'h0, 0);
      end else begin
        add_vec(1, 1, c, 0, 1, 0, 30'h0, 4'h0, 1, 30'h26666666, 4'd15, 0);
      end
    end
    add_vec(1, 1, 2'b10, 0, 1, 0, 30'h2,  4'd1, 0, 30'h0,  4'h0, 0);
    add_vec(1, 1, 2'b01, 0, 1, 0, 30'h9,  4'd2, 0, 30'h0,  4'h0, 0);
    add_vec(1, 1, 2'b11, 0, 1, 0, 30'h27, 4'd3, 0, 30'h0,  4'h0, 0);
    add_vec(1, 0, 2'b00, 1, 1, 0, 30'h0,  4'd0, 1, 30'h27, 4'd3, 0);
    add_vec(1, 0, 2'b00, 1, 1, 0, 30'h0,  4'd0, 0, 30'h0,  4'h0, 0);
    r = '0;
    for (int i = 0; i < 15; i++) begin
      if (i < 14) begin
        r = (r << 2) | 30'h2;
        add_vec(1, 1, 2'b10, 0, 1, 0, r, 4'(i + 1), 0, 30'h0, 4'h0, 0);
      end else begin
        add_vec(1, 1, 2'b10, 0, 1, 0, 30'h0, 4'h0, 1, 30'h2AAAAAAA, 4'd15, 0);
      end
    end
    add_vec(1, 0, 2'b00, 0, 1, 0, 30'h0, 4'd0, 0, 30'h0, 4'h0, 0);

    foreach (table_q[i]) begin
      string t;
      t = $sformatf("tbl%0d", i);
      applyStimulus(t, table_q[i].trc, table_q[i].valid, table_q[i].code,
                    table_q[i].fl, table_q[i].rdy, table_q[i].oclr);
      check_val({t, ".exp_buf"}, 32'(dct_buffer), 32'(table_q[i].exp_buf));
      check_val({t, ".exp_cnt"}, 32'(dct_count), 32'(table_q[i].exp_cnt));
      check_val({t, ".exp_fv"}, 32'(frame_valid), 32'(table_q[i].exp_fv));
      if (table_q[i].exp_fv) begin
        check_val({t, ".exp_fd"}, 32'(frame_data), 32'(table_q[i].exp_fd));
        check_val({t, ".exp_fc"}, 32'(frame_count), 32'(table_q[i].exp_fc));
      end
      check_val({t, ".exp_ovf"}, 32'(overflow), 32'(table_q[i].exp_ovf));
    end

    // Overflow: downstream stalled over two full frames.
    for (int i = 0; i < 15; i++)
      applyStimulus("ovf_a", 1, 1, 2'($urandom_range(0, 3)), 0, 0, 0);
    held_data = frame_data;
    check_val("ovf_first_valid", 32'(frame_valid), 32'h1);
    for (int i = 0; i < 15; i++)
      applyStimulus("ovf_b", 1, 1, 2'($urandom_range(0, 3)), 0, 0, 0);
    check_val("ovf_set", 32'(overflow), 32'h1);
    check_val("ovf_held_data", 32'(frame_data), 32'(held_data));
    check_val("ovf_held_count", 32'(frame_count), 32'd15);
    applyStimulus("ovf_c", 1, 1, 2'b01, 0, 0, 0);
    applyStimulus("ovf_setclr", 1, 0, 2'b00, 1, 0, 1);
    check_val("ovf_set_wins", 32'(overflow), 32'h1);
    applyStimulus("ovf_clr", 1, 0, 2'b00, 0, 0, 1);
    check_val("ovf_cleared", 32'(overflow), 32'h0);
    applyStimulus("ovf_drain", 1, 0, 2'b00, 0, 1, 0);

    // Back-to-back: slot drains on the same edge the next frame completes.
    for (int i = 0; i < 29; i++)
      applyStimulus("b2b_fill", 1, 1, 2'($urandom_range(1, 3)), 0, 0, 0);
    applyStimulus("b2b_edge", 1, 1, 2'b11, 0, 1, 0);
    check_val("b2b_valid", 32'(frame_valid), 32'h1);
    check_val("b2b_count", 32'(frame_count), 32'd15);
    check_val("b2b_no_ovf", 32'(overflow), 32'h0);
    applyStimulus("b2b_drain", 1, 0, 2'b00, 0, 1, 0);

    // trc_on falls after 5 codes while dct_valid stays high.
    for (int i = 0; i < 5; i++)
      applyStimulus("trc_codes", 1, 1, 2'($urandom_range(0, 3)), 0, 0, 0);
    applyStimulus("trc_fall", 0, 1, 2'b10, 0, 0, 0);
    check_val("trc_fall_count", 32'(frame_count), 32'd5);
    for (int i = 0; i < 3; i++)
      applyStimulus("trc_off", 0, 1, 2'b11, 0, 0, 0);
    check_val("trc_off_ignored", 32'(dct_count), 32'd0);
    applyStimulus("trc_drain", 1, 0, 2'b00, 0, 1, 0);

    // Reset mid-frame with the slot occupied.
    for (int i = 0; i < 4; i++)
      applyStimulus("rst_pre", 1, 1, 2'b11, 0, 0, 0);
    applyStimulus("rst_flush", 1, 0, 2'b00, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus("rst_live", 1, 1, 2'b01, 0, 0, 0);
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++)
      applyStimulus("rst_post", 1, 1, 2'b10, 0, 1, 0);
    check_val("rst_post_data", 32'(frame_data), 32'h2AAAAAAA);

    // Randomized run against the model.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus("rand", ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 9) < 7),
                    2'($urandom_range(0, 3)),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) < 6),
                    ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
